ex_mem: RTL and testbench

//  EX->MEM pipeline register: receiving end of the EX stage result interface (wd/wreg/wdata, hi/lo/whilo).

---
 rtl/ex_mem_pkg.sv | 31 +++
 rtl/ex_mem_sat_counter.sv | 18 +
 rtl/ex_mem.sv | 102 ++++++++++
 tb/tb_ex_mem.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_pkg.sv
// Shared widths, constants and the EX result bundle for the EX->MEM pipeline register.
package ex_mem_pkg;

  localparam int RegBus       = 32;
  localparam int RegAddrBus   = 5;
  localparam int DoubleRegBus = 64;

  localparam logic [RegBus-1:0] ZeroWord = '0;
  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;
  localparam logic Stop         = 1'b1;
  localparam logic NoStop       = 1'b0;
  localparam logic RstEnable    = 1'b0;

  // Stall vector bit positions (PC, IF, ID, EX, MEM, WB)
  localparam int StallEx  = 3;
  localparam int StallMem = 4;

  typedef struct packed {
    logic [RegAddrBus-1:0] wd;
    logic                  wreg;
    logic [RegBus-1:0]     wdata;
    logic [RegBus-1:0]     hi;
    logic [RegBus-1:0]     lo;
    logic                  whilo;
  } ex_res_t;

  localparam ex_res_t ExResNop = '{wd: '0, wreg: WriteDisable, wdata: ZeroWord,
                                   hi: ZeroWord, lo: ZeroWord, whilo: WriteDisable};

endpackage

// File: rtl/ex_mem_sat_counter.sv
// Saturating up-counter with synchronous clear; used for the optional debug counters.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (clr)
      cnt <= '0;
    else if (inc && (cnt != {WIDTH{1'b1}}))
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/ex_mem.sv
// EX->MEM pipeline register with bubble/hold/flush handling and MADD/MSUB intermediate return.
// Define EXMEM_DBG_CNT_EN to add saturating bubble/hold debug counters.
module ex_mem
  import ex_mem_pkg::*;
#(
  parameter int STALL_W  = 6,
  parameter int CNT_W    = 2,
  parameter int DBGCNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_W-1:0]      stall,
  input  logic                    flush,
  input  logic [RegAddrBus-1:0]   ex_wd,
  input  logic                    ex_wreg,
  input  logic [RegBus-1:0]       ex_wdata,
  input  logic [RegBus-1:0]       ex_hi,
  input  logic [RegBus-1:0]       ex_lo,
  input  logic                    ex_whilo,
  input  logic [DoubleRegBus-1:0] hilo_i,
  input  logic [CNT_W-1:0]        cnt_i,
  output logic [RegAddrBus-1:0]   mem_wd,
  output logic                    mem_wreg,
  output logic [RegBus-1:0]       mem_wdata,
  output logic [RegBus-1:0]       mem_hi,
  output logic [RegBus-1:0]       mem_lo,
  output logic                    mem_whilo,
  output logic                    mem_valid,
  output logic [DoubleRegBus-1:0] hilo_o,
  output logic [CNT_W-1:0]        cnt_o
`ifdef EXMEM_DBG_CNT_EN
  ,
  output logic [DBGCNT_W-1:0]     dbg_bubble_cnt,
  output logic [DBGCNT_W-1:0]     dbg_hold_cnt
`endif
);

  ex_res_t ex_res, mem_res;
  logic    hold, bubble;

  // MEM stalled always holds; the illegal EX-run/MEM-stall combination falls in here too.
  assign hold   = (stall[StallMem] == Stop);
  assign bubble = (stall[StallEx] == Stop) && (stall[StallMem] == NoStop);

  assign ex_res = '{wd: ex_wd, wreg: ex_wreg, wdata: ex_wdata,
                    hi: ex_hi, lo: ex_lo, whilo: ex_whilo};

  always_ff @(posedge clk) begin
    if (rst == RstEnable || flush) begin
      mem_res   <= ExResNop;
      mem_valid <= 1'b0;
      hilo_o    <= '0;
      cnt_o     <= '0;
    end else if (hold) begin
      mem_res   <= mem_res;
      mem_valid <= mem_valid;
      hilo_o    <= hilo_o;
      cnt_o     <= cnt_o;
    end else if (bubble) begin
      // Data zeroed too so forwarding never matches a stale destination
      mem_res   <= ExResNop;
      mem_valid <= 1'b0;
      hilo_o    <= hilo_i;
      cnt_o     <= cnt_i;
    end else begin
      mem_res   <= ex_res;
      mem_valid <= 1'b1;
      hilo_o    <= '0;
      cnt_o     <= '0;
    end
  end

  assign mem_wd    = mem_res.wd;
  assign mem_wreg  = mem_res.wreg;
  assign mem_wdata = mem_res.wdata;
  assign mem_hi    = mem_res.hi;
  assign mem_lo    = mem_res.lo;
  assign mem_whilo = mem_res.whilo;

  logic unused_stall;
  assign unused_stall = ^{stall[StallEx-1:0], stall[STALL_W-1:StallMem+1]};

`ifdef EXMEM_DBG_CNT_EN
  logic dbg_live;
  assign dbg_live = (rst != RstEnable) && !flush;

  sat_counter #(.WIDTH(DBGCNT_W)) u_bubble_cnt (
    .clk (clk),
    .clr (rst == RstEnable),
    .inc (dbg_live && bubble),
    .cnt (dbg_bubble_cnt)
  );

  sat_counter #(.WIDTH(DBGCNT_W)) u_hold_cnt (
    .clk (clk),
    .clr (rst == RstEnable),
    .inc (dbg_live && hold),
    .cnt (dbg_hold_cnt)
  );
`endif

endmodule

// File: tb/tb_ex_mem.sv
// Self-checking bench for ex_mem: directed literal checks plus randomized run against a behavioural model.
module tb_ex_mem;

  localparam int STALL_W = 6;
  localparam int CNT_W   = 2;
`ifdef EXMEM_DBG_CNT_EN
  localparam int DBGW    = 2;
`else
  localparam int DBGW    = 16;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic [STALL_W-1:0] stall;
  logic               flush;
  logic [4:0]         ex_wd;
  logic               ex_wreg;
  logic [31:0]        ex_wdata, ex_hi, ex_lo;
  logic               ex_whilo;
  logic [63:0]        hilo_i;
  logic [CNT_W-1:0]   cnt_i;
  logic [4:0]         mem_wd;
  logic               mem_wreg;
  logic [31:0]        mem_wdata, mem_hi, mem_lo;
  logic               mem_whilo, mem_valid;
  logic [63:0]        hilo_o;
  logic [CNT_W-1:0]   cnt_o;
`ifdef EXMEM_DBG_CNT_EN
  logic [DBGW-1:0]    dbg_bubble_cnt, dbg_hold_cnt;
`endif

  always #5 clk = ~clk;

  ex_mem #(.STALL_W(STALL_W), .CNT_W(CNT_W), .DBGCNT_W(DBGW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
    .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_whilo(ex_whilo),
    .hilo_i(hilo_i), .cnt_i(cnt_i),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
    .mem_valid(mem_valid), .hilo_o(hilo_o), .cnt_o(cnt_o)
`ifdef EXMEM_DBG_CNT_EN
    , .dbg_bubble_cnt(dbg_bubble_cnt), .dbg_hold_cnt(dbg_hold_cnt)
`endif
  );

  int n_cmp  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the slot either takes EX, becomes empty (keeping the
  // multiply intermediate for EX), stays as it was, or is wiped.
  logic [4:0]  m_wd;
  logic        m_wreg, m_whilo, m_valid;
  logic [31:0] m_wdata, m_hi, m_lo;
  logic [63:0] m_hilo;
  int          m_cnt, m_bub, m_hold;

  always @(posedge clk) begin
    string what;
    int    maxv;
    maxv = (1 << DBGW) - 1;
    if (!rst)                            what = "reset";
    else if (flush)                      what = "flush";
    else if (stall[4])                   what = "hold";
    else if (stall[3])                   what = "bubble";
    else                                 what = "advance";
    case (what)
      "reset", "flush": begin
        {m_wd, m_wreg, m_wdata, m_hi, m_lo, m_whilo, m_valid} <= '0;
        m_hilo <= 64'd0; m_cnt <= 0;
        if (what == "reset") begin m_bub <= 0; m_hold <= 0; end
      end
      "bubble": begin
        {m_wd, m_wreg, m_wdata, m_hi, m_lo, m_whilo, m_valid} <= '0;
        m_hilo <= hilo_i; m_cnt <= int'(cnt_i);
        if (m_bub < maxv) m_bub <= m_bub + 1;
      end
      "hold": begin
        if (m_hold < maxv) m_hold <= m_hold + 1;
      end
      default: begin
        m_wd <= ex_wd; m_wreg <= ex_wreg; m_wdata <= ex_wdata;
        m_hi <= ex_hi; m_lo <= ex_lo; m_whilo <= ex_whilo; m_valid <= 1'b1;
        m_hilo <= 64'd0; m_cnt <= 0;
      end
    endcase
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_wd", 64'(mem_wd), 64'(m_wd));
      chk("m_wreg", 64'(mem_wreg), 64'(m_wreg));
      chk("m_wdata", 64'(mem_wdata), 64'(m_wdata));
      chk("m_hi", 64'(mem_hi), 64'(m_hi));
      chk("m_lo", 64'(mem_lo), 64'(m_lo));
      chk("m_whilo", 64'(mem_whilo), 64'(m_whilo));
      chk("m_valid", 64'(mem_valid), 64'(m_valid));
      chk("m_hilo", hilo_o, m_hilo);
      chk("m_cnt", 64'(cnt_o), 64'(m_cnt));
`ifdef EXMEM_DBG_CNT_EN
      chk("m_dbg_bub", 64'(dbg_bubble_cnt), 64'(m_bub));
      chk("m_dbg_hold", 64'(dbg_hold_cnt), 64'(m_hold));
`endif
    end
  end

  // Inputs change only at negedge; outputs are then checked at the next negedge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_ex(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                        input logic [31:0] hi, input logic [31:0] lo, input logic whilo);
    ex_wd = wd; ex_wreg = wreg; ex_wdata = wdata; ex_hi = hi; ex_lo = lo; ex_whilo = whilo;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; stall = '0;
    set_ex(5'h1f, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    hilo_i = '1; cnt_i = '1;
    cyc();
    cmp_en = 1'b1;
    cyc();
    chk("rst_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_valid", 64'(mem_valid), 64'd0);
    chk("rst_wreg", 64'(mem_wreg), 64'd0);
    chk("rst_hilo", hilo_o, 64'd0);
    chk("rst_cnt", 64'(cnt_o), 64'd0);

    // Advance
    rst = 1'b1;
    set_ex(5'd5, 1'b1, 32'h1234_5678, 32'h0, 32'h0, 1'b0);
    cyc();
    chk("adv_wdata", 64'(mem_wdata), 64'h1234_5678);
    chk("adv_wd", 64'(mem_wd), 64'd5);
    chk("adv_valid", 64'(mem_valid), 64'd1);

    // Bubble carries the multiply intermediate back
    stall = 6'b001111; hilo_i = 64'h0000_0001_0000_0002; cnt_i = 2'd1;
    cyc();
    chk("bub_wreg", 64'(mem_wreg), 64'd0);
    chk("bub_valid", 64'(mem_valid), 64'd0);
    chk("bub_hilo", hilo_o, 64'h1_0000_0002);
    chk("bub_cnt", 64'(cnt_o), 64'd1);
    stall = '0;
    cyc();
    chk("cons_hilo", hilo_o, 64'd0);
    chk("cons_cnt", 64'(cnt_o), 64'd0);

    // Hold keeps the slot while EX data churns
    set_ex(5'd5, 1'b1, 32'h1234_5678, 32'h0, 32'h0, 1'b0);
    cyc();
    stall = 6'b011111;
    for (int i = 0; i < 3; i++) begin
      ex_wdata = $urandom; cnt_i = 2'(i + 1);
      cyc();
      chk("hold_wdata", 64'(mem_wdata), 64'h1234_5678);
      chk("hold_cnt", 64'(cnt_o), 64'd0);
      chk("hold_valid", 64'(mem_valid), 64'd1);
    end

    // Flush beats a simultaneous bubble
    stall = 6'b001111; flush = 1'b1; ex_whilo = 1'b1; hilo_i = 64'hDEAD_BEEF_0000_0001; cnt_i = 2'd1;
    cyc();
    chk("fl_whilo", 64'(mem_whilo), 64'd0);
    chk("fl_hilo", hilo_o, 64'd0);
    chk("fl_cnt", 64'(cnt_o), 64'd0);
    flush = 1'b0;

`ifdef EXMEM_DBG_CNT_EN
    rst = 1'b0; stall = '0; cyc(); rst = 1'b1;
    stall = 6'b001111;
    for (int i = 0; i < 5; i++) cyc();
    chk("dbg_sat", 64'(dbg_bubble_cnt), 64'd3);
    rst = 1'b0;
    cyc();
    chk("dbg_clr", 64'(dbg_bubble_cnt), 64'd0);
    rst = 1'b1;
`endif

    // Randomized phase, checked every cycle by the compare process
    for (int i = 0; i < 400; i++) begin
      int r;
      rst   = ($urandom_range(0, 39) != 0);
      flush = ($urandom_range(0, 14) == 0);
      r = $urandom_range(0, 7);
      if (r < 4)       stall = 6'b000000;
      else if (r < 6)  stall = 6'b001111;
      else if (r == 6) stall = 6'b011111;
      else             stall = 6'b010000;
      set_ex(5'($urandom), 1'($urandom), $urandom, $urandom, $urandom, 1'($urandom));
      hilo_i = {$urandom, $urandom};
      cnt_i  = CNT_W'($urandom);
      cyc();
    end

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
